// File: rtl/dqn_pkg.sv
// Shared definitions for the DQN weight loader and the network top:
// default node counts, layer codes, per-layer word counts and loader FSM states.
package dqn_pkg;

   // Default network shape shared with the network top.
   localparam int DEF_NUMBER_OF_INPUT_NODE          = 2;
   localparam int DEF_NUMBER_OF_HIDDEN_NODE_LAYER_1 = 32;
   localparam int DEF_NUMBER_OF_HIDDEN_NODE_LAYER_2 = 32;
   localparam int DEF_NUMBER_OF_OUTPUT_NODE         = 3;

   // Layer codes on the weight-load port; code 0 is reserved and never emitted.
   localparam logic [1:0] LAYER_1 = 2'd1;
   localparam logic [1:0] LAYER_2 = 2'd2;
   localparam logic [1:0] LAYER_3 = 2'd3;

   // Loader sequencing states.
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LOAD_L1 = 3'd1,
      ST_LOAD_L2 = 3'd2,
      ST_LOAD_L3 = 3'd3,
      ST_DONE    = 3'd4
   } load_state_t;

   // Word counts per layer: each destination node carries one weight per source plus a bias.
   function automatic int l1_words(input int n_input, input int n_hidden1);
      return (n_input + 1) * n_hidden1;
   endfunction

   function automatic int l2_words(input int n_hidden1, input int n_hidden2);
      return (n_hidden1 + 1) * n_hidden2;
   endfunction

   function automatic int l3_words(input int n_hidden2, input int n_output);
      return (n_hidden2 + 1) * n_output;
   endfunction

endpackage

// File: rtl/dqn_weight_loader_if.sv
// Host-side word stream and network-side weight-write bus of the weight loader.
interface dqn_weight_loader_if #(
   parameter int DATA_WIDTH           = 32,
   parameter int LAYER_WIDTH          = 2,
   parameter int WEIGHT_COUNTER_WIDTH = 11
);

   logic                            i_start;
   logic                            i_data_valid;
   logic [DATA_WIDTH-1:0]           i_data;
   logic                            o_data_ready;
   logic                            o_weight_valid;
   logic [LAYER_WIDTH-1:0]          o_weight_layer;
   logic [WEIGHT_COUNTER_WIDTH-1:0] o_weight_addr;
   logic [DATA_WIDTH-1:0]           o_weight;
   logic                            o_busy;
   logic                            o_load_done;
   logic                            o_net_enable;
   logic [DATA_WIDTH-1:0]           o_checksum;

   // Loader side.
   modport slave (
      input  i_start, i_data_valid, i_data,
      output o_data_ready, o_weight_valid, o_weight_layer, o_weight_addr, o_weight,
             o_busy, o_load_done, o_net_enable, o_checksum
   );

   // Host / environment side.
   modport master (
      output i_start, i_data_valid, i_data,
      input  o_data_ready, o_weight_valid, o_weight_layer, o_weight_addr, o_weight,
             o_busy, o_load_done, o_net_enable, o_checksum
   );

endinterface

// File: rtl/dqn_weight_loader.sv
// Streams host weight words into the network's weight-load port in layer/address
// order, tracks a running XOR checksum and releases the network only after a
// complete load.
module dqn_weight_loader
   import dqn_pkg::*;
#(
   parameter int DATA_WIDTH                    = 32,
   parameter int LAYER_WIDTH                   = 2,
   parameter int WEIGHT_COUNTER_WIDTH          = 11,
   parameter int NUMBER_OF_INPUT_NODE          = DEF_NUMBER_OF_INPUT_NODE,
   parameter int NUMBER_OF_HIDDEN_NODE_LAYER_1 = DEF_NUMBER_OF_HIDDEN_NODE_LAYER_1,
   parameter int NUMBER_OF_HIDDEN_NODE_LAYER_2 = DEF_NUMBER_OF_HIDDEN_NODE_LAYER_2,
   parameter int NUMBER_OF_OUTPUT_NODE         = DEF_NUMBER_OF_OUTPUT_NODE
) (
   input logic               clk,
   input logic               rst,
   dqn_weight_loader_if.slave bus
);

   localparam int L1_WORDS = l1_words(NUMBER_OF_INPUT_NODE, NUMBER_OF_HIDDEN_NODE_LAYER_1);
   localparam int L2_WORDS = l2_words(NUMBER_OF_HIDDEN_NODE_LAYER_1, NUMBER_OF_HIDDEN_NODE_LAYER_2);
   localparam int L3_WORDS = l3_words(NUMBER_OF_HIDDEN_NODE_LAYER_2, NUMBER_OF_OUTPUT_NODE);
   localparam int ADDR_SPAN = 2 ** WEIGHT_COUNTER_WIDTH;

   // Every layer has to be addressable by the weight counter.
   if (L1_WORDS > ADDR_SPAN || L2_WORDS > ADDR_SPAN || L3_WORDS > ADDR_SPAN) begin : g_size_check
      $error("dqn_weight_loader: a layer word count exceeds the weight address range");
   end

   localparam logic [WEIGHT_COUNTER_WIDTH-1:0] L1_LAST = WEIGHT_COUNTER_WIDTH'(L1_WORDS - 1);
   localparam logic [WEIGHT_COUNTER_WIDTH-1:0] L2_LAST = WEIGHT_COUNTER_WIDTH'(L2_WORDS - 1);
   localparam logic [WEIGHT_COUNTER_WIDTH-1:0] L3_LAST = WEIGHT_COUNTER_WIDTH'(L3_WORDS - 1);

   load_state_t                     state;
   logic [WEIGHT_COUNTER_WIDTH-1:0] addr_cnt;
   logic                            data_ready;
   logic                            busy;
   logic                            weight_valid;
   logic [LAYER_WIDTH-1:0]          weight_layer;
   logic [WEIGHT_COUNTER_WIDTH-1:0] weight_addr;
   logic [DATA_WIDTH-1:0]           weight;
   logic                            load_done;
   logic                            net_enable;
   logic [DATA_WIDTH-1:0]           checksum;

   logic                            accept;
   logic [LAYER_WIDTH-1:0]          cur_layer;
   logic [WEIGHT_COUNTER_WIDTH-1:0] cur_last;
   load_state_t                     next_layer_state;

   assign accept = bus.i_data_valid && data_ready;

   // Per-state layer code, last address of that layer and the state that follows it.
   always_comb begin
      cur_layer        = LAYER_WIDTH'(LAYER_1);
      cur_last         = L1_LAST;
      next_layer_state = ST_LOAD_L2;
      case (state)
         ST_LOAD_L2: begin
            cur_layer        = LAYER_WIDTH'(LAYER_2);
            cur_last         = L2_LAST;
            next_layer_state = ST_LOAD_L3;
         end
         ST_LOAD_L3: begin
            cur_layer        = LAYER_WIDTH'(LAYER_3);
            cur_last         = L3_LAST;
            next_layer_state = ST_DONE;
         end
         default: begin
            cur_layer        = LAYER_WIDTH'(LAYER_1);
            cur_last         = L1_LAST;
            next_layer_state = ST_LOAD_L2;
         end
      endcase
   end

   // Load sequencer: state, address counter, registered weight write and status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_IDLE;
         addr_cnt     <= '0;
         data_ready   <= 1'b0;
         busy         <= 1'b0;
         weight_valid <= 1'b0;
         weight_layer <= '0;
         weight_addr  <= '0;
         weight       <= '0;
         load_done    <= 1'b0;
         net_enable   <= 1'b0;
         checksum     <= '0;
      end else begin
         weight_valid <= 1'b0;
         load_done    <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (bus.i_start) begin
                  // A reload withdraws the network enable at once; the old table is being overwritten.
                  state      <= ST_LOAD_L1;
                  addr_cnt   <= '0;
                  checksum   <= '0;
                  net_enable <= 1'b0;
                  data_ready <= 1'b1;
                  busy       <= 1'b1;
               end
            end
            ST_LOAD_L1, ST_LOAD_L2, ST_LOAD_L3: begin
               if (accept) begin
                  weight_valid <= 1'b1;
                  weight_layer <= cur_layer;
                  weight_addr  <= addr_cnt;
                  weight       <= bus.i_data;
                  checksum     <= checksum ^ bus.i_data;
                  if (addr_cnt == cur_last) begin
                     addr_cnt <= '0;
                     state    <= next_layer_state;
                     // Done pulse and enable land together with the final write.
                     if (state == ST_LOAD_L3) begin
                        data_ready <= 1'b0;
                        busy       <= 1'b0;
                        load_done  <= 1'b1;
                        net_enable <= 1'b1;
                     end
                  end else begin
                     addr_cnt <= addr_cnt + 1'b1;
                  end
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state      <= ST_IDLE;
               data_ready <= 1'b0;
               busy       <= 1'b0;
            end
         endcase
      end
   end

   assign bus.o_data_ready   = data_ready;
   assign bus.o_busy         = busy;
   assign bus.o_weight_valid = weight_valid;
   assign bus.o_weight_layer = weight_layer;
   assign bus.o_weight_addr  = weight_addr;
   assign bus.o_weight       = weight;
   assign bus.o_load_done    = load_done;
   assign bus.o_net_enable   = net_enable;
   assign bus.o_checksum     = checksum;

endmodule

// File: tb/tb_dqn_weight_loader.sv
// Directed bench for dqn_weight_loader: full loads (continuous and gapped host
// streams), ignored starts, idle traffic, mid-load reset and reload.
module tb_dqn_weight_loader;

   localparam int L1_N  = 96;
   localparam int L2_N  = 1056;
   localparam int L3_N  = 99;
   localparam int TOTAL = 1251;

   logic clk = 1'b0;
   logic rst;

   int n_assert = 0;
   int n_fail   = 0;

   logic [31:0] last_layer;
   logic [31:0] last_addr;
   logic [31:0] last_word;

   dqn_weight_loader_if #(
      .DATA_WIDTH(32), .LAYER_WIDTH(2), .WEIGHT_COUNTER_WIDTH(11)
   ) bus ();

   dqn_weight_loader #(
      .DATA_WIDTH(32),
      .LAYER_WIDTH(2),
      .WEIGHT_COUNTER_WIDTH(11),
      .NUMBER_OF_INPUT_NODE(2),
      .NUMBER_OF_HIDDEN_NODE_LAYER_1(32),
      .NUMBER_OF_HIDDEN_NODE_LAYER_2(32),
      .NUMBER_OF_OUTPUT_NODE(3)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   always #5 clk = ~clk;

   // Absolute time limit so the run can never hang.
   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] exp_layer(input int idx);
      if (idx < L1_N)             return 32'd1;
      else if (idx < L1_N + L2_N) return 32'd2;
      else                        return 32'd3;
   endfunction

   function automatic logic [31:0] exp_addr(input int idx);
      if (idx < L1_N)             return 32'(idx);
      else if (idx < L1_N + L2_N) return 32'(idx - L1_N);
      else                        return 32'(idx - L1_N - L2_N);
   endfunction

   task automatic check_all_zero(input string tag);
      chk({tag, "_wvalid"},  32'(bus.o_weight_valid), 32'd0);
      chk({tag, "_layer"},   32'(bus.o_weight_layer), 32'd0);
      chk({tag, "_addr"},    32'(bus.o_weight_addr),  32'd0);
      chk({tag, "_weight"},  bus.o_weight,            32'd0);
      chk({tag, "_cksum"},   bus.o_checksum,          32'd0);
      chk({tag, "_ready"},   32'(bus.o_data_ready),   32'd0);
      chk({tag, "_busy"},    32'(bus.o_busy),         32'd0);
      chk({tag, "_done"},    32'(bus.o_load_done),    32'd0);
      chk({tag, "_net_en"},  32'(bus.o_net_enable),   32'd0);
   endtask

   // One load from IDLE. Words are cval (if nonzero) or idx+1. Stops early after
   // abort_after accepted words; raises i_start while word start_at is offered.
   task automatic do_load(input bit random_valid, input logic [31:0] cval,
                          input int abort_after, input int start_at);
      int          idx;
      int          cycles;
      logic        v;
      logic [31:0] d;
      logic [31:0] cks;
      idx    = 0;
      cycles = 0;
      cks    = '0;
      bus.i_start      = 1'b1;
      bus.i_data_valid = 1'b0;
      tick();
      bus.i_start = 1'b0;
      chk("start_ready",    32'(bus.o_data_ready),   32'd1);
      chk("start_busy",     32'(bus.o_busy),         32'd1);
      chk("start_net_en",   32'(bus.o_net_enable),   32'd0);
      chk("start_cksum",    bus.o_checksum,          32'd0);
      chk("start_no_write", 32'(bus.o_weight_valid), 32'd0);
      while (idx < TOTAL && idx != abort_after && cycles < 6000) begin
         v = random_valid ? 1'($urandom_range(0, 1)) : 1'b1;
         d = (cval != 32'd0) ? cval : 32'(idx + 1);
         bus.i_data_valid = v;
         bus.i_data       = d;
         bus.i_start      = (idx == start_at);
         tick();
         bus.i_start = 1'b0;
         cycles++;
         if (v) begin
            cks = cks ^ d;
            chk("wvalid",    32'(bus.o_weight_valid), 32'd1);
            chk("layer",     32'(bus.o_weight_layer), exp_layer(idx));
            chk("addr",      32'(bus.o_weight_addr),  exp_addr(idx));
            chk("word",      bus.o_weight,            d);
            chk("load_done", 32'(bus.o_load_done),    32'(idx == TOTAL - 1));
            chk("net_en",    32'(bus.o_net_enable),   32'(idx == TOTAL - 1));
            last_layer = exp_layer(idx);
            last_addr  = exp_addr(idx);
            last_word  = d;
            idx++;
         end else begin
            chk("gap_wvalid",  32'(bus.o_weight_valid), 32'd0);
            chk("gap_layer",   32'(bus.o_weight_layer), last_layer);
            chk("gap_addr",    32'(bus.o_weight_addr),  last_addr);
            chk("gap_word",    bus.o_weight,            last_word);
            chk("gap_done",    32'(bus.o_load_done),    32'd0);
         end
         chk("checksum", bus.o_checksum,        cks);
         chk("ready",    32'(bus.o_data_ready), 32'(idx < TOTAL));
         chk("busy",     32'(bus.o_busy),       32'(idx < TOTAL));
      end
      bus.i_data_valid = 1'b0;
      if (cycles >= 6000) chk("load_timeout", 32'd0, 32'd1);
      if (idx == TOTAL) begin
         tick();
         chk("post_done_low",  32'(bus.o_load_done),    32'd0);
         chk("post_net_en",    32'(bus.o_net_enable),   32'd1);
         chk("post_ready",     32'(bus.o_data_ready),   32'd0);
         chk("post_busy",      32'(bus.o_busy),         32'd0);
         chk("post_wvalid",    32'(bus.o_weight_valid), 32'd0);
         chk("post_cksum",     bus.o_checksum,          cks);
         tick();
         chk("idle_net_en",    32'(bus.o_net_enable),   32'd1);
         chk("idle_cksum",     bus.o_checksum,          cks);
      end
   endtask

   initial begin
      rst              = 1'b1;
      bus.i_start      = 1'b0;
      bus.i_data_valid = 1'b0;
      bus.i_data       = '0;
      last_layer       = '0;
      last_addr        = '0;
      last_word        = '0;
      tick();
      tick();
      check_all_zero("reset");
      rst = 1'b0;

      // Host words offered while idle with no start are ignored.
      bus.i_data_valid = 1'b1;
      bus.i_data       = 32'hDEADBEEF;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("idle_ready",    32'(bus.o_data_ready),   32'd0);
         chk("idle_no_write", 32'(bus.o_weight_valid), 32'd0);
         chk("idle_busy",     32'(bus.o_busy),         32'd0);
      end
      bus.i_data_valid = 1'b0;
      tick();

      // Continuous stream 1..1251; XOR of 1..1251 is 0 (1251 mod 4 == 3).
      do_load(1'b0, 32'd0, -1, -1);
      chk("cont_final_cksum", bus.o_checksum,        32'h0000_0000);
      chk("cont_final_net",   32'(bus.o_net_enable), 32'd1);

      // Gapped stream with an i_start offered at word 500 (ignored).
      do_load(1'b1, 32'd0, -1, 500);
      chk("rand_final_cksum", bus.o_checksum,        32'h0000_0000);
      chk("rand_final_net",   32'(bus.o_net_enable), 32'd1);

      // Reload with a constant word: odd count leaves the word itself.
      do_load(1'b0, 32'hA5A5A5A5, -1, -1);
      chk("a5_final_cksum", bus.o_checksum,        32'hA5A5A5A5);
      chk("a5_final_net",   32'(bus.o_net_enable), 32'd1);

      // Reset after 200 accepted words, host still streaming.
      do_load(1'b0, 32'd0, 200, -1);
      rst              = 1'b1;
      bus.i_data_valid = 1'b1;
      bus.i_data       = 32'h12345678;
      tick();
      check_all_zero("midreset");
      rst        = 1'b0;
      last_layer = '0;
      last_addr  = '0;
      last_word  = '0;
      tick();
      chk("after_reset_no_write", 32'(bus.o_weight_valid), 32'd0);
      chk("after_reset_ready",    32'(bus.o_data_ready),   32'd0);
      bus.i_data_valid = 1'b0;
      tick();

      // Fresh load after the abort restarts at layer 1 address 0.
      do_load(1'b0, 32'd0, -1, -1);
      chk("restart_final_net", 32'(bus.o_net_enable), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
